esfa_cell_hs: RTL and testbench

- Parametrised next-generation ESFA memory cell. Holds one array element: arrDef, array_code, eltDef, rank, low, high, index, value.
- Executes the ESFA cell operations through a valid/ready command and response handshake, not a free-running selector.
- Field widths are generic, the encode range is configurable, and arithmetic saturates with an overflow flag.
- One instance per cell slot inside the ESFA cell array. The array controller broadcasts commands and collects responses.

---
 rtl/esfa_cell_hs.sv | 240 ++++++++++++++++++++++++
 tb/tb_esfa_cell_hs.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/esfa_cell_hs.sv
// esfa_cell_hs: one ESFA array element executing ops over a cmd/rsp valid-ready handshake.
// Define ESFA_CELL_HITCNT_EN to add the hit_count output (LOOKUP hits, saturating).
module esfa_cell_hs #(
    parameter int HW = 8,
    parameter int IW = 8,
    parameter int VW = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [HW-1:0]                handle,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [IW-1:0]                cmd_index,
    input  logic [VW-1:0]                cmd_value,
    input  logic [HW-1:0]                cmd_meta,
    input  logic                         cmd_is_meta,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_hit,
    output logic [(HW > VW ? HW : VW)-1:0] rsp_value,
    output logic [HW-1:0]                rsp_context,
    output logic                         ovf,
    output logic                         elt_def
`ifdef ESFA_CELL_HITCNT_EN
    , output logic [15:0]                hit_count
`endif
);
    localparam int RW = HW > VW ? HW : VW;
    localparam int XW = HW > IW ? HW : IW;
    localparam logic [HW:0] DEPTH_W = (HW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [2:0] {OP_UPDATE, OP_LOOKUP, OP_ENCODE, OP_CONGRUE_UP,
                              OP_CONGRUE_DOWN, OP_MARK_AVAIL, OP_ENRANK, OP_CLEAR} op_t;
    state_t state, state_n;
    op_t op_q;
    logic [IW-1:0] idx_q, index, n_index;
    logic [VW-1:0] val_q, value, n_value;
    logic [HW-1:0] meta_q, array_code, rank, low, high;
    logic [HW-1:0] n_code, n_rank, n_low, n_high, n_ctx;
    logic [RW-1:0] n_rv;
    logic [HW:0] t;
    logic isq_q, arr_def, n_arr, n_elt, n_hit, clamp, ci_eq, enc;

    // Saturating helpers return {clamped, result}.
    function automatic logic [HW:0] inc(input logic [HW-1:0] x);
        return (&x) ? {1'b1, x} : {1'b0, x + 1'b1};
    endfunction

    function automatic logic [HW:0] dec(input logic [HW-1:0] x);
        return (x == '0) ? {1'b1, x} : {1'b0, x - 1'b1};
    endfunction

    assign ci_eq = XW'(idx_q) == XW'(handle);
    assign enc = isq_q && arr_def && ({1'b0, meta_q} < DEPTH_W) && meta_q == array_code;

    always_comb begin
        state_n = state == IDLE ? (cmd_valid ? EXEC : IDLE) : state == EXEC ? RESP : rsp_ready ? IDLE : RESP;
        cmd_ready = state == IDLE && !reset;
        rsp_valid = state == RESP;
    end

    always_comb begin
        n_arr = arr_def;
        n_elt = elt_def;
        n_code = array_code;
        n_rank = rank;
        n_low = low;
        n_high = high;
        n_index = index;
        n_value = value;
        n_hit = 1'b0;
        n_rv = '0;
        n_ctx = '0;
        clamp = 1'b0;
        t = '0;
        case (op_q)
            OP_UPDATE: begin
                n_hit = meta_q == handle && isq_q;
                if (n_hit) begin
                    n_arr = 1'b1;
                    n_elt = 1'b1;
                    n_code = handle;
                    n_low = handle;
                    n_high = handle;
                    n_index = idx_q;
                    n_value = val_q;
                    n_rank = HW'(1);
                end
                n_rv = RW'(handle);
                n_ctx = handle;
            end
            OP_LOOKUP: begin
                n_hit = index == idx_q && low <= meta_q && meta_q <= high && isq_q;
                n_rv = RW'(value);
                n_ctx = rank;
            end
            OP_ENCODE: begin
                n_hit = enc;
                n_rv = RW'(array_code);
                n_ctx = array_code;
            end
            OP_CONGRUE_UP: begin
                if (ci_eq && isq_q) begin
                    t = inc(meta_q);
                    n_code = t[HW-1:0];
                    n_low = t[HW-1:0];
                    n_high = t[HW-1:0];
                    clamp |= t[HW];
                    t = inc(val_q[HW-1:0]);
                    n_rank = t[HW-1:0];
                    clamp |= t[HW];
                end else begin
                    if (arr_def && isq_q && array_code > meta_q) begin
                        t = inc(array_code);
                        n_code = t[HW-1:0];
                        clamp |= t[HW];
                    end
                    if (elt_def && isq_q && low > meta_q) begin
                        t = inc(low);
                        n_low = t[HW-1:0];
                        clamp |= t[HW];
                    end
                    if (elt_def && isq_q && high >= meta_q) begin
                        t = inc(high);
                        n_high = t[HW-1:0];
                        clamp |= t[HW];
                    end
                end
                n_hit = n_code != array_code || n_low != low || n_high != high || n_rank != rank;
            end
            OP_CONGRUE_DOWN: begin
                if (ci_eq && isq_q) begin
                    n_arr = 1'b0;
                    n_rank = '0;
                end
                if (elt_def && isq_q && meta_q < low) begin
                    t = dec(low);
                    n_low = t[HW-1:0];
                    clamp |= t[HW];
                    t = dec(high);
                    n_high = t[HW-1:0];
                    clamp |= t[HW];
                end else if (elt_def && isq_q && low <= meta_q && meta_q <= high) begin
                    t = dec(high);
                    n_high = t[HW-1:0];
                    clamp |= t[HW];
                end
                // An element whose range collapsed no longer exists.
                if (elt_def && n_low > n_high) begin
                    n_elt = 1'b0;
                    n_arr = 1'b0;
                    n_hit = 1'b1;
                end
                if (n_arr && isq_q && array_code > meta_q) begin
                    t = dec(array_code);
                    n_code = t[HW-1:0];
                    clamp |= t[HW];
                end
            end
            OP_MARK_AVAIL: begin
                n_hit = !elt_def;
                n_rv = RW'(handle);
                n_ctx = handle;
            end
            OP_ENRANK: begin
                n_hit = enc;
                n_rv = RW'(rank);
                n_ctx = rank;
            end
            OP_CLEAR: begin
                if (ci_eq) begin
                    n_arr = 1'b0;
                    n_elt = 1'b0;
                    n_code = '0;
                    n_rank = '0;
                    n_low = '0;
                    n_high = '0;
                    n_index = '0;
                    n_value = '0;
                    n_hit = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_q <= OP_UPDATE;
            idx_q <= '0;
            val_q <= '0;
            meta_q <= '0;
            isq_q <= 1'b0;
            arr_def <= 1'b0;
            elt_def <= 1'b0;
            array_code <= '0;
            rank <= '0;
            low <= '0;
            high <= '0;
            index <= '0;
            value <= '0;
            rsp_hit <= 1'b0;
            rsp_value <= '0;
            rsp_context <= '0;
            ovf <= 1'b0;
`ifdef ESFA_CELL_HITCNT_EN
            hit_count <= '0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE && cmd_valid) begin
                op_q <= op_t'(cmd_op);
                idx_q <= cmd_index;
                val_q <= cmd_value;
                meta_q <= cmd_meta;
                isq_q <= cmd_is_meta;
            end
            if (state == EXEC) begin
                arr_def <= n_arr;
                elt_def <= n_elt;
                array_code <= n_code;
                rank <= n_rank;
                low <= n_low;
                high <= n_high;
                index <= n_index;
                value <= n_value;
                rsp_hit <= n_hit;
                rsp_value <= n_rv;
                rsp_context <= n_ctx;
                ovf <= ovf | clamp;
`ifdef ESFA_CELL_HITCNT_EN
                hit_count <= (op_q == OP_CLEAR && ci_eq) ? '0 :
                             (op_q == OP_LOOKUP && n_hit && !(&hit_count)) ? hit_count + 1'b1 : hit_count;
`endif
            end
        end
    end
endmodule

// File: tb/tb_esfa_cell_hs.sv
// tb_esfa_cell_hs: directed scoreboard bench for esfa_cell_hs built with HW=4 to reach saturation.
module tb_esfa_cell_hs;
    localparam int HW = 4, IW = 8, VW = 8, DEPTH = 8;
    localparam logic [2:0] UPD = 3'd0, LKP = 3'd1, ENC = 3'd2, CUP = 3'd3;
    localparam logic [2:0] CDN = 3'd4, MAV = 3'd5, ENR = 3'd6, CLR = 3'd7;

    logic clk = 1'b0, reset = 1'b1;
    logic [HW-1:0] handle = 4'd3;
    logic cmd_valid = 1'b0, cmd_ready, cmd_is_meta = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [IW-1:0] cmd_index = '0;
    logic [VW-1:0] cmd_value = '0;
    logic [HW-1:0] cmd_meta = '0;
    logic rsp_valid, rsp_ready = 1'b1, rsp_hit, ovf, elt_def;
    logic [7:0] rsp_value;
    logic [HW-1:0] rsp_context;
`ifdef ESFA_CELL_HITCNT_EN
    logic [15:0] hit_count;
`endif

    typedef struct {
        logic       hit;
        logic [7:0] val;
        logic [3:0] ctx;
    } exp_t;
    exp_t sbq[$];
    int vecs = 0, errs = 0;

    esfa_cell_hs #(.HW(HW), .IW(IW), .VW(VW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .handle(handle),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_index(cmd_index), .cmd_value(cmd_value), .cmd_meta(cmd_meta),
        .cmd_is_meta(cmd_is_meta), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_value(rsp_value), .rsp_context(rsp_context),
        .ovf(ovf), .elt_def(elt_def)
`ifdef ESFA_CELL_HITCNT_EN
        , .hit_count(hit_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_rsp: hit=%0b value=%0h with empty scoreboard", rsp_hit, rsp_value);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
                    chk("rsp_value", 32'(rsp_value), 32'(e.val));
                    chk("rsp_context", 32'(rsp_context), 32'(e.ctx));
                end
            end
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] idx, input logic [7:0] val,
                         input logic [3:0] m, input logic q,
                         input logic h, input logic [7:0] ev, input logic [3:0] ec);
        int n = 0;
        while (!cmd_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            vecs++;
            errs++;
            $display("FAIL issue_timeout: cmd_ready=0 required 1 for op %0d", op);
            return;
        end
        sbq.push_back('{hit: h, val: ev, ctx: ec});
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_index = idx;
        cmd_value = val;
        cmd_meta = m;
        cmd_is_meta = q;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sbq.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
        chk("rst_rsp_value", 32'(rsp_value), 32'd0);
        chk("rst_rsp_context", 32'(rsp_context), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_elt_def", 32'(elt_def), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        // Update then lookup, with first-response latency
        issue(UPD, 8'd5, 8'h2A, 4'd3, 1'b1, 1'b1, 8'd3, 4'd3);
        chk("lat_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("lat_exec_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
        issue(LKP, 8'd5, 8'd0, 4'd3, 1'b1, 1'b1, 8'h2A, 4'd1);
        drain();
        chk("upd_elt_def", 32'(elt_def), 32'd1);
        // Congruence up shifts code/low/high to 4
        issue(CUP, 8'd9, 8'd0, 4'd2, 1'b1, 1'b1, 8'd0, 4'd0);
        issue(ENC, 8'd0, 8'd0, 4'd3, 1'b1, 1'b0, 8'd4, 4'd4);
        issue(ENC, 8'd0, 8'd0, 4'd4, 1'b1, 1'b1, 8'd4, 4'd4);
        issue(ENR, 8'd0, 8'd0, 4'd4, 1'b1, 1'b1, 8'd1, 4'd1);
        issue(LKP, 8'd5, 8'd0, 4'd4, 1'b1, 1'b1, 8'h2A, 4'd1);
        issue(LKP, 8'd5, 8'd0, 4'd3, 1'b1, 1'b0, 8'h2A, 4'd1);
        drain();
        chk("cup_ovf_clear", 32'(ovf), 32'd0);
        // Saturation at 2^HW-1 sets sticky ovf
        handle = 4'd15;
        issue(UPD, 8'h33, 8'h44, 4'd15, 1'b1, 1'b1, 8'd15, 4'd15);
        issue(CUP, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 8'd0, 4'd0);
        drain();
        chk("sat_ovf", 32'(ovf), 32'd1);
        issue(LKP, 8'h33, 8'd0, 4'd15, 1'b1, 1'b1, 8'h44, 4'd1);
        issue(ENR, 8'd0, 8'd0, 4'd15, 1'b1, 1'b0, 8'd1, 4'd1);
        drain();
        chk("sat_ovf_sticky", 32'(ovf), 32'd1);
        // Congruence down collapses the element
        handle = 4'd3;
        issue(UPD, 8'd7, 8'h11, 4'd3, 1'b1, 1'b1, 8'd3, 4'd3);
        issue(CDN, 8'd0, 8'd0, 4'd3, 1'b1, 1'b1, 8'd0, 4'd0);
        drain();
        chk("cdn_elt_def", 32'(elt_def), 32'd0);
        issue(MAV, 8'd0, 8'd0, 4'd0, 1'b0, 1'b1, 8'd3, 4'd3);
        issue(CLR, 8'd5, 8'd0, 4'd0, 1'b0, 1'b0, 8'd0, 4'd0);
        issue(CLR, 8'd3, 8'd0, 4'd0, 1'b0, 1'b1, 8'd0, 4'd0);
        issue(LKP, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 8'd0, 4'd0);
        issue(CUP, 8'd3, 8'd4, 4'd6, 1'b1, 1'b1, 8'd0, 4'd0);
        issue(ENR, 8'd0, 8'd0, 4'd7, 1'b1, 1'b0, 8'd5, 4'd5);
        issue(ENC, 8'd0, 8'd0, 4'd7, 1'b1, 1'b0, 8'd7, 4'd7);
        issue(UPD, 8'd9, 8'd9, 4'd2, 1'b1, 1'b0, 8'd3, 4'd3);
        issue(LKP, 8'd0, 8'd0, 4'd7, 1'b1, 1'b1, 8'd0, 4'd5);
        issue(LKP, 8'd0, 8'd0, 4'd7, 1'b0, 1'b0, 8'd0, 4'd5);
        issue(UPD, 8'd1, 8'd9, 4'd3, 1'b1, 1'b1, 8'd3, 4'd3);
        issue(CDN, 8'd0, 8'd0, 4'd1, 1'b1, 1'b0, 8'd0, 4'd0);
        issue(LKP, 8'd1, 8'd0, 4'd2, 1'b1, 1'b1, 8'd9, 4'd1);
        issue(ENC, 8'd0, 8'd0, 4'd2, 1'b1, 1'b1, 8'd2, 4'd2);
        drain();
        chk("cdn_shift_elt_def", 32'(elt_def), 32'd1);
        // Backpressure: response held, next command waits
        rsp_ready = 1'b0;
        issue(MAV, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 8'd3, 4'd3);
        sbq.push_back('{hit: 1'b1, val: 8'd9, ctx: 4'd1});
        cmd_valid = 1'b1;
        cmd_op = LKP;
        cmd_index = 8'd1;
        cmd_meta = 4'd2;
        cmd_is_meta = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_rsp_hit", 32'(rsp_hit), 32'd0);
            chk("bp_rsp_value", 32'(rsp_value), 32'd3);
            chk("bp_rsp_context", 32'(rsp_context), 32'd3);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_accept_cmd_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        drain();
        // Reset during EXEC of UPDATE
        issue(UPD, 8'd5, 8'h2A, 4'd3, 1'b1, 1'b1, 8'd3, 4'd3);
        void'(sbq.pop_back());
        chk("mid_exec_cmd_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_elt_def", 32'(elt_def), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("mid_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        issue(LKP, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 8'd0, 4'd0);
        issue(MAV, 8'd0, 8'd0, 4'd0, 1'b0, 1'b1, 8'd3, 4'd3);
        issue(ENC, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 8'd0, 4'd0);
        drain();
        // Decrement clamp at zero
        handle = 4'd0;
        issue(UPD, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 8'd0, 4'd0);
        issue(CDN, 8'd5, 8'd0, 4'd0, 1'b1, 1'b0, 8'd0, 4'd0);
        drain();
        chk("dec_clamp_ovf", 32'(ovf), 32'd1);
        chk("dec_clamp_elt_def", 32'(elt_def), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
